ascon_perm_scheduler: RTL

Sequences and shares the single Ascon round-function datapath between two requesters: the p^a port (initialization/finalization, 12 rounds) and the p^b port (data/associated-data processing, 6 or 8 rounds). Arbitrates requests, runs the round counter, and drives the round-constant index, select and enable into the round datapath. Signals completion back to the owning requester. Sits between the mode FSM (encrypt/decrypt/hash control) and the permutation datapath.

---
 rtl/ascon_perm_scheduler_if.sv | 47 ++++
 rtl/ascon_perm_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_scheduler_if.sv
// ---------------------------------------------------------------------------
// ascon_perm_scheduler_if
//
// Bundle between the mode FSM / round datapath and the permutation
// scheduler.
//
//   req_a, req_b   requester -> scheduler  level requests for p^a / p^b
//   flush          requester -> scheduler  synchronous abort of current run
//   gnt_a, gnt_b   scheduler -> requester  grant pulse (first round cycle)
//   done_a, done_b scheduler -> requester  result-valid pulse
//   owner          scheduler -> datapath   input-mux select (0 = p^a)
//   round_valid    scheduler -> datapath   apply one round this cycle
//   round_idx      scheduler -> datapath   round-constant index 0..11
//   last_round     scheduler -> datapath   final round of the permutation
//   busy           scheduler -> requester  permutation in progress
//   counter        scheduler -> requester  rounds completed so far
//
// The master modport is the requester/datapath side, the slave modport is
// the scheduler itself.
// ---------------------------------------------------------------------------
interface ascon_perm_scheduler_if;
    logic       req_a;
    logic       req_b;
    logic       flush;
    logic       gnt_a;
    logic       gnt_b;
    logic       owner;
    logic       round_valid;
    logic [3:0] round_idx;
    logic       last_round;
    logic       done_a;
    logic       done_b;
    logic       busy;
    logic [3:0] counter;

    modport master (
        output req_a, req_b, flush,
        input  gnt_a, gnt_b, owner, round_valid, round_idx, last_round,
               done_a, done_b, busy, counter
    );

    modport slave (
        input  req_a, req_b, flush,
        output gnt_a, gnt_b, owner, round_valid, round_idx, last_round,
               done_a, done_b, busy, counter
    );
endinterface

// File: rtl/ascon_perm_scheduler.sv
// ---------------------------------------------------------------------------
// ascon_perm_scheduler
//
// Shares one Ascon round-function datapath between the p^a requester
// (initialization / finalization) and the p^b requester (data / AD
// processing). Arbitrates round-robin on ties, counts rounds, and drives
// the round-constant index, owner select and round enable.
//
// Parameters
//   PA_ROUNDS  rounds for a p^a permutation (1..12)
//   PB_ROUNDS  rounds for a p^b permutation (1..12; 6 for Ascon-128,
//              8 for Ascon-128a)
//
// Ports
//   clk   single clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   slave side of ascon_perm_scheduler_if (requests, grants,
//         done pulses and datapath controls)
//
// Every output is decoded from registered state only, so there is no
// combinational path from req_a/req_b/flush to any output, and an
// asynchronous reset forces all outputs low immediately.
// ---------------------------------------------------------------------------
module ascon_perm_scheduler #(
    parameter int PA_ROUNDS = 12,
    parameter int PB_ROUNDS = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    ascon_perm_scheduler_if.slave       bus
);

    // Round counts and the first round-constant index for each owner.
    // Starting at (12 - N) makes the final round always use index 11.
    localparam logic [3:0] PA_N    = 4'(PA_ROUNDS);
    localparam logic [3:0] PB_N    = 4'(PB_ROUNDS);
    localparam logic [3:0] PA_BASE = 4'(12 - PA_ROUNDS);
    localparam logic [3:0] PB_BASE = 4'(12 - PB_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state,    state_d;
    logic       own,      own_d;       // 0 = p^a, 1 = p^b
    logic [3:0] ctr,      ctr_d;       // rounds completed in RUN
    logic       last_gnt, last_gnt_d;  // requester granted most recently

    logic [3:0] n_rounds;
    logic [3:0] idx_base;
    logic [3:0] final_ctr;
    logic       pick;

    assign n_rounds  = own ? PB_N    : PA_N;
    assign idx_base  = own ? PB_BASE : PA_BASE;
    assign final_ctr = n_rounds - 4'd1;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            own      <= 1'b0;
            ctr      <= 4'd0;
            last_gnt <= 1'b1;   // p^a wins the first tie after reset
        end else begin
            state    <= state_d;
            own      <= own_d;
            ctr      <= ctr_d;
            last_gnt <= last_gnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state;
        own_d      = own;
        ctr_d      = ctr;
        last_gnt_d = last_gnt;

        // On a tie the requester not granted last time wins; otherwise
        // the single active requester wins.
        pick = (bus.req_a && bus.req_b) ? ~last_gnt : bus.req_b;

        unique case (state)
            ST_IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    state_d    = ST_RUN;
                    own_d      = pick;
                    last_gnt_d = pick;
                    ctr_d      = 4'd0;
                end
            end

            ST_RUN: begin
                if (bus.flush) begin
                    // Abort without a done pulse; last_gnt stays updated.
                    state_d = ST_IDLE;
                    ctr_d   = 4'd0;
                end else if (ctr == final_ctr) begin
                    state_d = ST_DONE;
                end else begin
                    ctr_d = ctr + 4'd1;
                end
            end

            ST_DONE: begin
                // Single result cycle; flush here ends up in IDLE as well.
                state_d = ST_IDLE;
                ctr_d   = 4'd0;
            end

            default: begin
                state_d = ST_IDLE;
                ctr_d   = 4'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (registered state only)
    // -----------------------------------------------------------------------
    always_comb begin
        bus.busy        = 1'b0;
        bus.owner       = 1'b0;
        bus.round_valid = 1'b0;
        bus.round_idx   = 4'd0;
        bus.last_round  = 1'b0;
        bus.gnt_a       = 1'b0;
        bus.gnt_b       = 1'b0;
        bus.done_a      = 1'b0;
        bus.done_b      = 1'b0;
        bus.counter     = 4'd0;

        unique case (state)
            ST_RUN: begin
                bus.busy        = 1'b1;
                bus.owner       = own;
                bus.round_valid = 1'b1;
                bus.round_idx   = idx_base + ctr;
                bus.last_round  = (ctr == final_ctr);
                // The grant pulse marks the cycle the owner's state is
                // muxed into the datapath.
                bus.gnt_a       = (ctr == 4'd0) && !own;
                bus.gnt_b       = (ctr == 4'd0) &&  own;
                bus.counter     = ctr;
            end

            ST_DONE: begin
                bus.busy    = 1'b1;
                bus.owner   = own;
                bus.done_a  = !own;
                bus.done_b  =  own;
                bus.counter = n_rounds;
            end

            default: begin
                // IDLE: all outputs stay at their zero defaults.
            end
        endcase
    end

endmodule
